seven_seg_scanner: RTL and testbench
====================================

// Module: seven_seg_scanner
// PURPOSE
//  Time-multiplexed driver for N common-anode 7-segment digits plus decimal points.
//  Hex nibbles are loaded through a strobe into a shadow register and applied only at
//  frame boundaries, so the display never tears. Adds dead-time, leading-zero blanking
//  and an optional blink. Sits between board-level display logic and the AN/SEG pins.
// PARAMETERS
//  N_DIGITS      4       digits scanned (1..8)
//  DIGIT_CYCLES  100000  clk cycles per digit slot (>= DEAD_CYCLES+1)
//  DEAD_CYCLES   2000    cycles at the start of each slot with all anodes off (anti-ghost)
//  BLINK_FRAMES  250     frames per blink half-period (SEVSEG_BLINK_EN only)
// PORTS
//  clk       in   1           system clock
//  rst       in   1           synchronous reset, active-high
//  value     in   4*N_DIGITS  nibble k = digit k (digit 0 = rightmost)
//  dp        in   N_DIGITS    decimal point per digit, 1 = lit
//  load      in   1           strobe: capture value/dp into shadow this cycle
//  lz_blank  in   1           1 = blank leading zero digits
//  pending   out  1           shadow holds data not yet shown
//  frame     out  1           1-cycle pulse when the scan wraps to digit 0
//  an        out  N_DIGITS    anodes, active-low
//  seg       out  8           {dp,g,f,e,d,c,b,a}, active-low; 8'hFF = dark
// BEHAVIOUR
//  - Reset: slot counter = 0, digit index = 0, an = all 1s, seg = 8'hFF, pending = 0,
//    frame = 0, shadow and active registers = 0.
//  - Slot counter runs 0..DIGIT_CYCLES-1. On wrap, digit index advances, N_DIGITS-1 -> 0.
//  - Frame boundary = the cycle the counter wraps and digit index goes N_DIGITS-1 -> 0.
//    frame pulses on that cycle.
//  - an and seg are registered, one cycle behind the counter state.
//  - While counter < DEAD_CYCLES: an = all 1s, seg = 8'hFF. Otherwise an has only bit
//    [idx] low, and seg = {~dp[idx], hexenc(active nibble idx)}.
//  - Hex encoding (a..g, active-low): 0-9 decimal, A b C d E F.
//  - load=1: shadow <= value/dp and pending <= 1. A later load before the boundary
//    overwrites the earlier one (last wins).
//  - Frame boundary with pending=1: active <= shadow, pending <= 0.
//  - load on the boundary cycle itself: active <= the live value/dp bus directly and
//    pending stays 0. The load bypasses the shadow.
//  - Leading-zero blank (evaluated on active data): digit k is blanked if lz_blank=1 and
//    all nibbles k..N_DIGITS-1 are 0, with k>0. Digit 0 is never blanked.
//    Blanked means seg = 8'hFF and the anode is still driven. dp is suppressed too.
//  - Reset mid-frame: all state returns to reset values on the next edge and the scan
//    restarts at digit 0 with dead-time.
// CONFIGURATION
//  SEVSEG_BLINK_EN defined:
//   - Adds input port blink[N_DIGITS-1:0] and a frame counter.
//   - Blink phase toggles every BLINK_FRAMES frames. Reset phase = on.
//   - In the off phase, digits with blink[k]=1 are blanked (seg = 8'hFF).
//   - blink is sampled live, not through the shadow.
//  SEVSEG_BLINK_EN undefined:
//   - No blink port, no frame counter. All digits always show.
// TESTING (N_DIGITS=4, DIGIT_CYCLES=8, DEAD_CYCLES=2, BLINK_FRAMES=2)
//  1. rst 3 cycles, then load value=16'h12AF dp=0 -> pending=1.
//     After the first boundary: an cycles 1110,1101,1011,0111; seg 8E,88,A4,F9.
//     Each slot shows 2 dead cycles (an=1111, seg=FF) then 6 lit cycles.
//  2. Loads of 16'h1111 then 16'h2222 within one frame -> next frame shows all digits
//    8'hA4. 1111 never appears on seg.
//  3. load 16'h0000 on the boundary cycle -> next slot shows 0, pending stays 0.
//  4. lz_blank=1, value=16'h0050 -> digits 3,2 give seg=FF with an low.
//     Digit 1 shows 92, digit 0 shows C0. value=0 -> only digit 0 lit.
//  5. dp=4'b0100, value=16'h0000, lz_blank=0 -> digit 2 seg=8'h40, others 8'hC0.
//  6. Assert rst mid-slot on digit 2 -> next edge an=1111, seg=FF, pending=0.
//    With SEVSEG_BLINK_EN, blink=4'b0001 -> digit 0 dark on alternate 2-frame periods.

Source files
------------

// File: rtl/seven_seg_scanner.sv
// Multiplexed common-anode 7-segment scanner with frame-synchronous shadow load.
// Optional blink support is enabled by defining SEVSEG_BLINK_EN.
module seven_seg_scanner #(
  parameter int N_DIGITS     = 4,
  parameter int DIGIT_CYCLES = 100000,
  parameter int DEAD_CYCLES  = 2000,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic                  load,
  input  logic                  lz_blank,
`ifdef SEVSEG_BLINK_EN
  input  logic [N_DIGITS-1:0]   blink,
`endif
  output logic                  pending,
  output logic                  frame,
  output logic [N_DIGITS-1:0]   an,
  output logic [7:0]            seg
);

  localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [4*N_DIGITS-1:0] shadow;
  logic [N_DIGITS-1:0]   shadow_dp;
  logic [4*N_DIGITS-1:0] active;
  logic [N_DIGITS-1:0]   active_dp;

  logic                  wrap;
  logic                  boundary;
  logic                  dead;
  logic [3:0]            nib;
  logic                  dsel;
  logic                  off;
  logic [N_DIGITS-1:0]   lz_mask;
  logic                  zero_run;

  function automatic logic [6:0] hexenc(input logic [3:0] h);
    logic [6:0] s;
    s = 7'h7F;
    unique case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign wrap     = (cnt == CW'(DIGIT_CYCLES - 1));
  assign boundary = wrap && (idx == IW'(N_DIGITS - 1));
  assign dead     = (cnt < CW'(DEAD_CYCLES));
  assign frame    = boundary;

`ifdef SEVSEG_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [FW-1:0] fcnt;
  logic          phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt  <= '0;
      phase <= 1'b1;
    end else if (boundary) begin
      if (fcnt == FW'(BLINK_FRAMES - 1)) begin
        fcnt  <= '0;
        phase <= ~phase;
      end else begin
        fcnt <= fcnt + FW'(1);
      end
    end
  end
`endif

  // Blanking walks down from the top digit while every nibble seen is zero.
  always_comb begin
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      zero_run   = zero_run && (active[4*k +: 4] == 4'h0);
      lz_mask[k] = lz_blank && zero_run && (k != 0);
    end
  end

  always_comb begin
    nib  = 4'h0;
    dsel = 1'b0;
    off  = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        nib  = active[4*k +: 4];
        dsel = active_dp[k];
        off  = lz_mask[k];
`ifdef SEVSEG_BLINK_EN
        off  = off || (!phase && blink[k]);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= '0;
      shadow    <= '0;
      shadow_dp <= '0;
      active    <= '0;
      active_dp <= '0;
      pending   <= 1'b0;
      an        <= '1;
      seg       <= 8'hFF;
    end else begin
      cnt <= wrap ? '0 : cnt + CW'(1);
      if (wrap)
        idx <= boundary ? '0 : idx + IW'(1);

      if (load) begin
        shadow    <= value;
        shadow_dp <= dp;
      end

      // A load on the boundary itself goes straight to the display.
      if (boundary) begin
        if (load) begin
          active    <= value;
          active_dp <= dp;
        end else if (pending) begin
          active    <= shadow;
          active_dp <= shadow_dp;
        end
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end

      if (dead) begin
        an  <= '1;
        seg <= 8'hFF;
      end else begin
        an  <= ~(N_DIGITS'(1) << idx);
        seg <= off ? 8'hFF : {~dsel, hexenc(nib)};
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: expected frames are queued at
// load time and popped while the scan runs.
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        load;
  logic        lz_blank;
  logic        pending;
  logic        frame;
  logic [3:0]  an;
  logic [7:0]  seg;
`ifdef SEVSEG_BLINK_EN
  logic [3:0]  blink = 4'b0000;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .N_DIGITS(4),
    .DIGIT_CYCLES(8),
    .DEAD_CYCLES(2),
    .BLINK_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .value(value),
    .dp(dp),
    .load(load),
    .lz_blank(lz_blank),
`ifdef SEVSEG_BLINK_EN
    .blink(blink),
`endif
    .pending(pending),
    .frame(frame),
    .an(an),
    .seg(seg)
  );

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] t[16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[h];
  endfunction

  // Queue the dead and lit samples of one full frame.
  task automatic push_frame(input logic [15:0] v, input logic [3:0] d,
                            input logic lz);
    logic [3:0] a;
    logic [7:0] s;
    logic       blank;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back({4'hF, 8'hFF});
      a     = ~(4'b0001 << k);
      blank = lz && (k > 0) && ((v >> (4 * k)) == 16'h0);
      s     = blank ? 8'hFF : {~d[k], hex7(v[4*k +: 4])};
      exp_q.push_back({a, s});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves time positioned on the boundary cycle.
  task automatic wait_frame(input string tag);
    int n;
    n = 0;
    while (frame !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    if (frame !== 1'b1)
      chk({tag, "_frame_timeout"}, 16'h0, 16'h1);
  endtask

  // Starts on state cnt=0, idx=0 and ends on the next frame's cnt=0.
  task automatic check_frame(input string tag);
    logic [11:0] e;
    for (int k = 0; k < 4; k++) begin
      step();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'h000;
      chk($sformatf("%s_d%0d_dead", tag, k), {4'h0, an, seg}, {4'h0, e});
      repeat (4) step();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'h000;
      chk($sformatf("%s_d%0d_lit", tag, k), {4'h0, an, seg}, {4'h0, e});
      repeat (3) step();
    end
  endtask

  initial begin
    rst      = 1'b1;
    value    = 16'h0;
    dp       = 4'h0;
    load     = 1'b0;
    lz_blank = 1'b0;
    repeat (3) step();
    chk("rst_an", {12'h0, an}, 16'h000F);
    chk("rst_seg", {8'h0, seg}, 16'h00FF);
    chk("rst_pending", {15'h0, pending}, 16'h0);
    chk("rst_frame", {15'h0, frame}, 16'h0);
    rst = 1'b0;

    // 1: basic load through the shadow
    value = 16'h12AF;
    load  = 1'b1;
    step();
    load = 1'b0;
    chk("t1_pending", {15'h0, pending}, 16'h1);
    push_frame(16'h12AF, 4'h0, 1'b0);
    wait_frame("t1");
    step();
    chk("t1_pending_clr", {15'h0, pending}, 16'h0);
    check_frame("t1");

    // 2: last load before the boundary wins
    value = 16'h1111;
    load  = 1'b1;
    step();
    value = 16'h2222;
    step();
    load = 1'b0;
    push_frame(16'h2222, 4'h0, 1'b0);
    wait_frame("t2");
    step();
    check_frame("t2");

    // 3: load on the boundary bypasses the shadow
    wait_frame("t3");
    value = 16'h0000;
    load  = 1'b1;
    step();
    load = 1'b0;
    chk("t3_pending", {15'h0, pending}, 16'h0);
    push_frame(16'h0000, 4'h0, 1'b0);
    check_frame("t3");

    // 4: leading-zero blanking
    value    = 16'h0050;
    lz_blank = 1'b1;
    load     = 1'b1;
    step();
    load = 1'b0;
    push_frame(16'h0050, 4'h0, 1'b1);
    wait_frame("t4a");
    step();
    check_frame("t4a");
    value = 16'h0000;
    load  = 1'b1;
    step();
    load = 1'b0;
    push_frame(16'h0000, 4'h0, 1'b1);
    wait_frame("t4b");
    step();
    check_frame("t4b");

    // 5: decimal point on digit 2
    lz_blank = 1'b0;
    dp       = 4'b0100;
    load     = 1'b1;
    step();
    load = 1'b0;
    push_frame(16'h0000, 4'b0100, 1'b0);
    wait_frame("t5");
    step();
    check_frame("t5");

    // 6: reset in the middle of digit 2
    dp    = 4'h0;
    value = 16'h1234;
    load  = 1'b1;
    step();
    load = 1'b0;
    repeat (19) step();
    chk("t6_pre_pending", {15'h0, pending}, 16'h1);
    chk("t6_pre_an", {12'h0, an}, 16'h000B);
    rst = 1'b1;
    step();
    chk("t6_an", {12'h0, an}, 16'h000F);
    chk("t6_seg", {8'h0, seg}, 16'h00FF);
    chk("t6_pending", {15'h0, pending}, 16'h0);
    rst = 1'b0;
    push_frame(16'h0000, 4'h0, 1'b0);
    check_frame("t6_restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
